// File: rtl/stack_cpu_sequencer_if.sv
// Load stream and memory write port of the stack CPU run controller.
// The sequencer sits on the slave side; the host/loader and memory sit on the master side.
interface stack_cpu_sequencer_if;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;

  modport master (
    output load_valid, load_data, load_last,
    input  load_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  load_valid, load_data, load_last,
    output load_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_cpu_sequencer.sv
// Run controller for the 8-bit stack CPU: loads a program, seeds the
// mailbox bytes, then single-steps the core until halt, timeout or fault.
module stack_cpu_sequencer #(
  parameter int END_ADDR    = 37,
  parameter int MAX_STEPS   = 255,
  parameter int PROG_LIMIT  = 252,
  parameter int STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] x,
  stack_cpu_sequencer_if.slave bus,
  output logic       cpu_rst,
  output logic       cpu_step,
  input  logic [7:0] cpu_pc,
  input  logic [3:0] cpu_sp,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       fault,
  output logic [7:0] step_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    INIT,
    RUN,
    DONE
  } state_e;

  localparam logic [7:0] END_PC   = 8'(END_ADDR);
  localparam logic [7:0] STEP_MAX = 8'(MAX_STEPS);
  localparam logic [7:0] PROG_MAX = 8'(PROG_LIMIT);
  localparam logic [3:0] SP_MAX   = 4'(STACK_DEPTH);

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] x_q, x_d;
  logic [7:0] step_q, step_d;
  logic       timeout_q, timeout_d;
  logic       fault_q, fault_d;
  logic [1:0] init_q, init_d;

  logic sp_bad;
  logic pc_end;
  logic budget_out;

  // sp is 4 bits, so an underflow wrap to 15 is caught here too
  assign sp_bad     = cpu_sp > SP_MAX;
  assign pc_end     = cpu_pc == END_PC;
  assign budget_out = step_q == STEP_MAX;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    x_d            = x_q;
    step_d         = step_q;
    timeout_d      = timeout_q;
    fault_d        = fault_q;
    init_d         = init_q;
    bus.load_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = 8'd0;
    bus.mem_wdata  = 8'd0;
    cpu_step       = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          x_d       = x;
          step_d    = 8'd0;
          timeout_d = 1'b0;
          fault_d   = 1'b0;
          addr_d    = 8'd0;
        end
      end
      LOAD: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = addr_q;
          bus.mem_wdata = bus.load_data;
          addr_d        = addr_q + 8'd1;
          if (bus.load_last) begin
            state_d = INIT;
            init_d  = 2'd0;
          end else if (addr_q == PROG_MAX) begin
            state_d = DONE;
            fault_d = 1'b1;
          end
        end
      end
      INIT: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = 8'd253 + {6'd0, init_q};
        bus.mem_wdata = (init_q == 2'd2) ? x_q : 8'd0;
        init_d        = init_q + 2'd1;
        if (init_q == 2'd2) begin
          state_d = RUN;
          init_d  = 2'd0;
        end
      end
      RUN: begin
        if (sp_bad) begin
          state_d = DONE;
          fault_d = 1'b1;
        end else if (pc_end) begin
          state_d = DONE;
        end else if (budget_out) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else begin
          cpu_step = 1'b1;
          if (step_q != 8'hFF) begin
            step_d = step_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 8'd0;
      x_q       <= 8'd0;
      step_q    <= 8'd0;
      timeout_q <= 1'b0;
      fault_q   <= 1'b0;
      init_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      x_q       <= x_d;
      step_q    <= step_d;
      timeout_q <= timeout_d;
      fault_q   <= fault_d;
      init_q    <= init_d;
    end
  end

  assign cpu_rst    = (state_q == IDLE) || (state_q == LOAD) ||
                      (state_q == INIT);
  assign busy       = (state_q == LOAD) || (state_q == INIT) ||
                      (state_q == RUN);
  assign done       = state_q == DONE;
  assign timeout    = timeout_q;
  assign fault      = fault_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_stack_cpu_sequencer.sv
// Scoreboarded bench for stack_cpu_sequencer with a behavioural CPU stand-in.
// Expected memory writes are queued as beats are driven and popped on mem_we.
module tb_stack_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x = 8'd0;
  logic       cpu_rst;
  logic       cpu_step;
  logic [7:0] cpu_pc = 8'd0;
  logic [3:0] cpu_sp = 4'd0;
  logic       busy;
  logic       done;
  logic       timeout;
  logic       fault;
  logic [7:0] step_count;

  int tests = 0;
  int fails = 0;
  int mode = 0;
  int step_seen = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic [7:0]  mem [256];

  always #5 clk = ~clk;

  stack_cpu_sequencer_if bus ();

  stack_cpu_sequencer #(
    .MAX_STEPS(50)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .x         (x),
    .bus       (bus),
    .cpu_rst   (cpu_rst),
    .cpu_step  (cpu_step),
    .cpu_pc    (cpu_pc),
    .cpu_sp    (cpu_sp),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .fault     (fault),
    .step_count(step_count)
  );

  // CPU stand-in: 0 linear, 1 loop 0..2, 2 sp wraps to 15, 3 sp sits at 8
  always @(posedge clk) begin
    if (cpu_rst) begin
      cpu_pc <= 8'd0;
      cpu_sp <= 4'd0;
    end else if (cpu_step) begin
      case (mode)
        1: cpu_pc <= (cpu_pc == 8'd2) ? 8'd0 : cpu_pc + 8'd1;
        2: begin
          cpu_pc <= cpu_pc + 8'd1;
          cpu_sp <= 4'd15;
        end
        3: begin
          cpu_pc <= cpu_pc + 8'd1;
          cpu_sp <= 4'd8;
        end
        default: cpu_pc <= cpu_pc + 8'd1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cpu_step) step_seen++;
    if (bus.mem_we) begin
      mem[bus.mem_addr] = bus.mem_wdata;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mem_write unexpected addr=%0d data=%0d required none",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== mon_e) begin
          fails++;
          $display("FAIL mem_write got addr=%0d data=%0d required addr=%0d data=%0d",
                   bus.mem_addr, bus.mem_wdata, mon_e[15:8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic pulse_start(input logic [7:0] xv);
    @(posedge clk);
    #1;
    start = 1'b1;
    x = xv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_prog(input logic [7:0] prog[$], input logic [7:0] xv,
                           input bit use_last, input bit poke);
    for (int i = 0; i < prog.size(); i++) begin
      if (i % 5 == 3) begin
        bus.load_valid = 1'b0;
        start = poke;
        x = ~xv;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = xv;
      end
      bus.load_valid = 1'b1;
      bus.load_data = prog[i];
      bus.load_last = use_last && (i == prog.size() - 1);
      exp_q.push_back({8'(i), prog[i]});
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b0;
    bus.load_last = 1'b0;
    if (use_last) begin
      exp_q.push_back({8'd253, 8'd0});
      exp_q.push_back({8'd254, 8'd0});
      exp_q.push_back({8'd255, xv});
    end
  endtask

  task automatic run_case(input logic [7:0] prog[$], input logic [7:0] xv,
                          input int m, input bit use_last, input bit poke);
    mode = m;
    step_seen = 0;
    pulse_start(xv);
    load_prog(prog, xv, use_last, poke);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s wait_done got done=0 required done=1 within 500 cycles",
               name);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({cpu_rst, busy, done, timeout, fault, cpu_step, bus.load_ready,
         bus.mem_we, step_count} !== {1'b1, 7'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_state got rst=%b busy=%b done=%b to=%b flt=%b step=%b rdy=%b we=%b cnt=%0d",
               cpu_rst, busy, done, timeout, fault, cpu_step,
               bus.load_ready, bus.mem_we, step_count);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_linear;
    logic [7:0] prog[$];
    for (int i = 0; i < 37; i++) prog.push_back(8'($urandom_range(0, 255)));
    run_case(prog, 8'd10, 0, 1'b1, 1'b0);
    wait_done("linear");
    tests++;
    if ({step_count, timeout, fault, busy} !== {8'd37, 3'b000}) begin
      fails++;
      $display("FAIL linear_status got cnt=%0d to=%b flt=%b busy=%b required cnt=37 to=0 flt=0 busy=0",
               step_count, timeout, fault, busy);
    end
    tests++;
    if ({mem[253], mem[254], mem[255]} !== {8'd0, 8'd0, 8'd10}) begin
      fails++;
      $display("FAIL linear_mailbox got %0d %0d %0d required 0 0 10",
               mem[253], mem[254], mem[255]);
    end
    tests++;
    if (step_seen !== 37) begin
      fails++;
      $display("FAIL linear_steps got %0d required 37", step_seen);
    end
  endtask

  task automatic test_start_ignored;
    logic [7:0] prog[$];
    for (int i = 0; i < 37; i++) prog.push_back(8'(i * 7));
    run_case(prog, 8'd200, 3, 1'b1, 1'b1);
    wait_done("sp_edge");
    tests++;
    if ({step_count, timeout, fault} !== {8'd37, 2'b00}) begin
      fails++;
      $display("FAIL sp_edge_status got cnt=%0d to=%b flt=%b required cnt=37 to=0 flt=0",
               step_count, timeout, fault);
    end
    tests++;
    if (mem[255] !== 8'd200) begin
      fails++;
      $display("FAIL start_in_load_x got %0d required 200", mem[255]);
    end
  endtask

  task automatic test_timeout;
    logic [7:0] prog[$];
    prog = '{8'h00, 8'h00, 8'h30};
    run_case(prog, 8'd3, 1, 1'b1, 1'b0);
    wait_done("timeout");
    repeat (5) @(negedge clk);
    tests++;
    if ({done, step_count, timeout, fault} !== {1'b1, 8'd50, 2'b10}) begin
      fails++;
      $display("FAIL timeout_status got done=%b cnt=%0d to=%b flt=%b required done=1 cnt=50 to=1 flt=0",
               done, step_count, timeout, fault);
    end
    tests++;
    if (step_seen !== 50) begin
      fails++;
      $display("FAIL timeout_steps got %0d required 50", step_seen);
    end
  endtask

  task automatic test_stack_fault;
    logic [7:0] prog[$];
    prog = '{8'h30};
    run_case(prog, 8'd1, 2, 1'b1, 1'b0);
    wait_done("stack_fault");
    tests++;
    if ({step_count, timeout, fault, cpu_rst} !== {8'd1, 3'b010}) begin
      fails++;
      $display("FAIL stack_fault got cnt=%0d to=%b flt=%b rst=%b required cnt=1 to=0 flt=1 rst=0",
               step_count, timeout, fault, cpu_rst);
    end
  endtask

  task automatic test_overflow;
    logic [7:0] prog[$];
    for (int i = 0; i < 253; i++) prog.push_back(8'($urandom_range(0, 255)));
    run_case(prog, 8'd9, 0, 1'b0, 1'b0);
    bus.load_valid = 1'b1;
    bus.load_data = 8'hAA;
    repeat (3) @(negedge clk);
    tests++;
    if ({done, fault, timeout, bus.load_ready, bus.mem_we, step_count} !==
        {5'b11000, 8'd0}) begin
      fails++;
      $display("FAIL overflow got done=%b flt=%b to=%b rdy=%b we=%b cnt=%0d required done=1 flt=1 to=0 rdy=0 we=0 cnt=0",
               done, fault, timeout, bus.load_ready, bus.mem_we, step_count);
    end
    bus.load_valid = 1'b0;
    tests++;
    if (step_seen !== 0) begin
      fails++;
      $display("FAIL overflow_steps got %0d required 0", step_seen);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] prog[$];
    prog = '{8'h00, 8'h00, 8'h30};
    run_case(prog, 8'd4, 1, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    tests++;
    if ({busy, cpu_rst} !== 2'b10 || step_seen == 0) begin
      fails++;
      $display("FAIL mid_run_pre got busy=%b rst=%b steps=%0d required busy=1 rst=0 steps>0",
               busy, cpu_rst, step_seen);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({cpu_rst, busy, done, step_count} !== {3'b100, 8'd0}) begin
      fails++;
      $display("FAIL mid_run_reset got rst=%b busy=%b done=%b cnt=%0d required rst=1 busy=0 done=0 cnt=0",
               cpu_rst, busy, done, step_count);
    end
    test_linear();
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data = 8'd0;
    bus.load_last = 1'b0;
    test_reset();
    test_linear();
    test_start_ignored();
    test_timeout();
    test_stack_fault();
    test_overflow();
    test_reset_mid_run();
    repeat (4) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_writes got %0d required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_cpu_sequencer.md
Name: stack_cpu_sequencer

Overview:
Run controller for the 8-bit stack CPU and its 256x8 unified memory.
- Streams a program image into memory and initialises the mailbox bytes (253 error, 254 result, 255 input x).
- Releases the CPU for single-instruction steps until a halt address, step limit or stack fault is reached.
- Sits between the host or loader interface and the CPU core; it owns the memory write port during load and init.

Parameters:
END_ADDR, 37, PC value at which the program is complete
MAX_STEPS, 255, instruction budget before timeout (1..255)
PROG_LIMIT, 252, highest memory address a program byte may occupy
STACK_DEPTH, 8, legal stack entries; sp above this is a fault

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins load, ignored unless IDLE or DONE
x  in  8  input operand, captured on accepted start
load_valid  in  1  program byte valid
load_data  in  8  program byte
load_last  in  1  marks final program byte
load_ready  out  1  sequencer accepts byte (high only in LOAD)
mem_we  out  1  memory write strobe
mem_addr  out  8  memory write address
mem_wdata  out  8  memory write data
cpu_rst  out  1  holds CPU pc/sp/flags at zero
cpu_step  out  1  CPU executes one instruction this cycle
cpu_pc  in  8  CPU program counter (registered in core)
cpu_sp  in  4  CPU stack pointer (registered in core)
busy  out  1  high in LOAD, INIT, RUN
done  out  1  high in DONE
timeout  out  1  sticky in DONE: step budget exhausted
fault  out  1  sticky in DONE: stack fault or load overflow
step_count  out  8  instructions executed in current run

Behaviour:
Reset:
- rst_n low at a clock edge puts the block in IDLE.
- All outputs 0 except cpu_rst=1. step_count=0, load address=0.
- Reset mid-operation abandons any load or run immediately; no further mem_we.

States IDLE, LOAD, INIT, RUN, DONE.

IDLE:
- cpu_rst=1.
- start -> LOAD; capture x; clear step_count, timeout, fault; load address=0.

LOAD:
- load_ready=1.
- A beat is accepted when load_valid and load_ready are high. On a beat: mem_we=1, mem_addr=load address, mem_wdata=load_data, same cycle (combinational from the accepted beat); load address increments.
- Beat with load_last -> INIT next cycle.
- Beat at address PROG_LIMIT without load_last -> DONE with fault=1. That byte is still written.
- No beat -> hold state.
- start is ignored.

INIT:
- Exactly 3 cycles with mem_we=1: addr 253 data 0, then 254 data 0, then 255 data captured x.
- cpu_rst=1 throughout. Then -> RUN.

RUN:
- cpu_rst=0.
- Halt conditions are evaluated combinationally on cpu_pc/cpu_sp each cycle, in this priority:
  1. cpu_sp > STACK_DEPTH (covers underflow wrap to 15) -> DONE, fault=1.
  2. cpu_pc == END_ADDR -> DONE.
  3. step_count == MAX_STEPS -> DONE, timeout=1.
- cpu_step=1 only when in RUN and no halt condition holds.
- step_count increments on each cycle with cpu_step=1 and saturates at 255.
- The first RUN cycle sees pc=0, sp=0.

DONE:
- cpu_step=0, cpu_rst=0, so memory and CPU state stay readable.
- done, timeout, fault and step_count hold.
- start -> LOAD, full restart.

General rules:
- mem_we is 0 in IDLE, RUN and DONE. The CPU's own stores happen in RUN through the core's port; the memory wrapper muxes core vs sequencer by busy && !RUN.
- start asserted in the same cycle as a halt is ignored; the block enters DONE first.

Test Plan:
1. Load the 37-byte reference program, x=10 -> 37 beats, 3 init writes, RUN. Expect done with step_count=20, mem[254]=54, mem[253]=0, timeout=0, fault=0.
2. Same program, x=200 -> sign jump taken. Expect done, step_count=7, mem[253]=1, mem[254]=0.
3. Program "push 0; jump" (bytes 00 00 30) looping to 0, MAX_STEPS=50 -> done, timeout=1, step_count=50, cpu_step never asserted on the 51st cycle.
4. Program starting with single byte 0x30 (jump on empty stack, sp wraps to 15) -> step_count=1, then fault=1, done.
5. Stream 253 bytes with load_last never set -> write at 252 occurs, then DONE with fault=1, load_ready low, no write to 253.
6. Assert rst_n=0 mid-RUN for one cycle -> next cycle state IDLE, cpu_rst=1, busy=0, step_count=0. A new start re-runs scenario 1 with an identical result.
